// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller.
// Turns one-cycle go/hold/stop/lap pulses into the tick counter's
// start/pause level encoding. Counts the counter's tick toggles into an
// mm:ss elapsed time, captures laps, and raises an alarm at a target time.
//
// Command handshake: all commands are single-cycle pulses sampled on
// every rising clock edge. There is no backpressure. A command that does
// not apply in the current state is dropped. When several commands apply
// in the same cycle, stop wins over hold, and hold wins over go.
module stopwatch_ctrl #(
  parameter int TICKS_PER_SEC = 1,
  parameter int MAX_MIN       = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_i,
  input  logic       hold_i,
  input  logic       stop_i,
  input  logic       lap_i,
  input  logic       target_en_i,
  input  logic [6:0] target_min_i,
  input  logic [5:0] target_sec_i,
  input  logic       cnt_tick_i,
  output logic       cnt_start_o,
  output logic       cnt_pause_o,
  output logic [6:0] min_o,
  output logic [5:0] sec_o,
  output logic [6:0] lap_min_o,
  output logic [5:0] lap_sec_o,
  output logic       running_o,
  output logic       paused_o,
  output logic       alarm_o,
  output logic       wrap_o,
  output logic [2:0] state_o
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  // The counter leaves PAUSE only through start&!pause. That is why a stop
  // issued from PAUSED or DONE passes through STOP_A before reaching STOP_B.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSED = 3'd2,
    S_DONE   = 3'd3,
    S_STOP_A = 3'd4,
    S_STOP_B = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             tick_q;
  logic [SUB_W-1:0] sub;
  logic [SUB_W-1:0] sub_nxt;
  logic [6:0]       min_nxt;
  logic [5:0]       sec_nxt;
  logic             wrap_nxt;
  logic             tick_edge;
  logic             target_hit;

  assign state_o = state;

  // Advance the elapsed time when a tick edge is seen while running.
  always_comb begin
    sub_nxt   = sub;
    min_nxt   = min_o;
    sec_nxt   = sec_o;
    wrap_nxt  = 1'b0;
    tick_edge = (state == S_RUN) && (cnt_tick_i ^ tick_q);
    if (tick_edge) begin
      if (sub == SUB_W'(TICKS_PER_SEC - 1)) begin
        sub_nxt = '0;
        if (sec_o == 6'd59) begin
          sec_nxt = 6'd0;
          if (min_o == 7'(MAX_MIN)) begin
            min_nxt  = 7'd0;
            wrap_nxt = 1'b1;
          end else begin
            min_nxt = min_o + 7'd1;
          end
        end else begin
          sec_nxt = sec_o + 6'd1;
        end
      end else begin
        sub_nxt = sub + SUB_W'(1);
      end
    end
    // A target of 00:00 is treated as "no target".
    target_hit = target_en_i && ((target_min_i != 7'd0) || (target_sec_i != 6'd0)) &&
                 (min_nxt == target_min_i) && (sec_nxt == target_sec_i);
  end

  // Next-state selection with stop > hold > go priority.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go_i) state_nxt = S_RUN;
      S_RUN: begin
        if (stop_i)          state_nxt = S_STOP_B;
        else if (hold_i)     state_nxt = S_PAUSED;
        else if (target_hit) state_nxt = S_DONE;
      end
      S_PAUSED: begin
        if (stop_i)    state_nxt = S_STOP_A;
        else if (go_i) state_nxt = S_RUN;
      end
      S_DONE:   if (stop_i) state_nxt = S_STOP_A;
      S_STOP_A: state_nxt = S_STOP_B;
      S_STOP_B: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, time, lap and registered status/counter-drive outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      tick_q      <= 1'b0;
      sub         <= '0;
      min_o       <= 7'd0;
      sec_o       <= 6'd0;
      lap_min_o   <= 7'd0;
      lap_sec_o   <= 6'd0;
      cnt_start_o <= 1'b0;
      cnt_pause_o <= 1'b0;
      running_o   <= 1'b0;
      paused_o    <= 1'b0;
      alarm_o     <= 1'b0;
      wrap_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_q      <= cnt_tick_i;
      cnt_start_o <= (state_nxt == S_RUN) || (state_nxt == S_STOP_A) ||
                     (state_nxt == S_PAUSED) || (state_nxt == S_DONE);
      cnt_pause_o <= (state_nxt == S_PAUSED) || (state_nxt == S_DONE);
      running_o   <= (state_nxt == S_RUN);
      paused_o    <= (state_nxt == S_PAUSED);
      alarm_o     <= (state_nxt == S_DONE);
      wrap_o      <= wrap_nxt;
      if (state == S_IDLE && go_i) begin
        sub   <= '0;
        min_o <= 7'd0;
        sec_o <= 6'd0;
      end else begin
        sub   <= sub_nxt;
        min_o <= min_nxt;
        sec_o <= sec_nxt;
      end
      if (lap_i && (state == S_RUN || state == S_PAUSED || state == S_DONE)) begin
        lap_min_o <= min_nxt;
        lap_sec_o <= sec_nxt;
      end
    end
  end

endmodule
